// File: rtl/xmit_fifo_ctrl.sv
// Transmit byte FIFO plus load sequencer feeding a UART transmitter.
// Optional sticky overflow flag 'ovf' is built when XMIT_FIFO_OVF_EN is defined.
module xmit_fifo_ctrl #(
    parameter int DW           = 8,
    parameter int AW           = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          tx_busy,
    output logic          load,
    output logic [DW-1:0] tx_din,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
`ifdef XMIT_FIFO_OVF_EN
    ,
    output logic          ovf
`endif
);
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 2);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [TW-1:0] tmo;
    logic [AW:0]   count_nxt;
    logic          wr_ok;
    logic          pop;

    // full/empty are registered, so both checks use pre-edge flags
    assign wr_ok = wr_en && !full;
    assign pop   = (state == S_IDLE) && !empty && !tx_busy;

    always_comb begin
        count_nxt = count;
        if (wr_ok && !pop)
            count_nxt = count + (AW+1)'(1);
        else if (pop && !wr_ok)
            count_nxt = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            load   <= 1'b0;
            tx_din <= '0;
            rd_ptr <= '0;
            tmo    <= '0;
        end else begin
            load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_din <= mem[rd_ptr];
                        rd_ptr <= rd_ptr + AW'(1);
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    load  <= 1'b1;
                    tmo   <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // no busy response: re-issue the same byte, retries unbounded
                    if (tx_busy)
                        state <= S_WAIT_DONE;
                    else if (tmo == TW'(BUSY_TIMEOUT))
                        state <= S_LOAD;
                    else
                        tmo <= tmo + TW'(1);
                end
                S_WAIT_DONE: begin
                    if (!tx_busy)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef XMIT_FIFO_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (wr_en && full)
            ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_xmit_fifo_ctrl.sv
// Bench for xmit_fifo_ctrl: vector table for fill/first frame, scoreboard of
// queued bytes checked at every load pulse, hand sequences for timing corners.
module tb_xmit_fifo_ctrl;
    localparam int BT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_busy;
    logic       load;
    logic [7:0] tx_din;
    logic       full;
    logic       empty;
    logic [4:0] count;
`ifdef XMIT_FIFO_OVF_EN
    logic       ovf;
`endif

    xmit_fifo_ctrl #(.DW(8), .AW(4), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .tx_busy(tx_busy), .load(load), .tx_din(tx_din), .full(full),
        .empty(empty), .count(count)
`ifdef XMIT_FIFO_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_busy;
        logic       load;
        logic       empty;
        logic       full;
        logic [4:0] count;
        logic [7:0] din;
    } vec_t;

    vec_t       tbl [23];
    logic [7:0] sbq [$];
    int         checks = 0;
    int         errors = 0;
    bit         sb_on = 1'b1;
    bit         xm_on = 1'b0;
    int         busy_len = 3;
    int         busy_left = 0;
    logic [7:0] frame_din;
    int         stab_err = 0;
    int         nload = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock; inputs were set before the edge, outputs are looked at 1ns after it.
    task automatic step();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (load) nload++;
        if (sb_on && load) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_load", {24'h0, tx_din}, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("sb_load_byte", {24'h0, tx_din}, {24'h0, e});
            end
        end
        if (xm_on) begin
            if (busy_left > 0) begin
                if (tx_din !== frame_din) stab_err++;
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end else if (load) begin
                frame_din = tx_din;
                tx_busy   = 1'b1;
                busy_left = busy_len;
            end
        end
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        xm_on = 1'b1;
        tx_busy = 1'b0;
        wr_en = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            step();
            if (sbq.size() == 0 && busy_left == 0) done = 1'b1;
        end
        chk({name, "_drain_done"}, {31'h0, done}, 32'h1);
        for (int n = 0; n < 3; n++) step();
        xm_on = 1'b0;
        tx_busy = 1'b0;
        chk({name, "_stable"}, stab_err, 0);
        chk({name, "_final"}, {count, empty, full}, {5'd0, 1'b1, 1'b0});
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        sbq.delete();
    endtask

    initial begin
        logic prev_full;
        int   gap;
        int   errs;
        int   n0;
        bit   seen;

        // test 1 rows: single byte, frame handshake, back to idle
        tbl[0] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h3C};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h3C};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h3C};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h3C};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h3C};
        // test 2 rows: fill to 16 with transmitter busy, then one dropped write
        for (int i = 0; i < 16; i++)
            tbl[6+i] = '{1'b1, 8'(i), 1'b1, 1'b0, 1'b0, (i == 15), 5'(i + 1), 8'h3C};
        tbl[22] = '{1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1, 5'd16, 8'h3C};

        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
        #12;
        chk("reset_state", {load, tx_din, full, empty, count}, {1'b0, 8'h00, 1'b0, 1'b1, 5'd0});
`ifdef XMIT_FIFO_OVF_EN
        chk("reset_ovf", {31'h0, ovf}, 32'h0);
`endif
        rst_n = 1'b1;

        prev_full = 1'b0;
        for (int i = 0; i < 23; i++) begin
            wr_en = tbl[i].wr_en; wr_data = tbl[i].wr_data; tx_busy = tbl[i].tx_busy;
            if (tbl[i].wr_en && !prev_full) sbq.push_back(tbl[i].wr_data);
            step();
            chk($sformatf("vec%0d", i), {load, empty, full, count, tx_din},
                {tbl[i].load, tbl[i].empty, tbl[i].full, tbl[i].count, tbl[i].din});
            prev_full = tbl[i].full;
        end
        busy_len = 3;
        drain("t2");
        n0 = nload;
        for (int n = 0; n < 30; n++) step();
        chk("t2_no_extra_load", nload - n0, 0);

        // test 3: long frame, tx_din held, next pop/load timing after busy falls
        wr_en = 1'b1; wr_data = 8'h5A; sbq.push_back(8'h5A); step();
        wr_data = 8'h6B; sbq.push_back(8'h6B); step();
        chk("t3_pop", {load, count, tx_din}, {1'b0, 5'd1, 8'h5A});
        wr_en = 1'b0; step();
        chk("t3_load1", {31'h0, load}, 32'h1);
        tx_busy = 1'b1;
        errs = 0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (tx_din !== 8'h5A || load !== 1'b0) errs++;
        end
        chk("t3_hold100", errs, 0);
        tx_busy = 1'b0; step();
        chk("t3_idle_edge", {load, tx_din}, {1'b0, 8'h5A});
        step();
        chk("t3_pop_edge", {load, tx_din, count, empty}, {1'b0, 8'h6B, 5'd0, 1'b1});
        step();
        chk("t3_load2", {31'h0, load}, 32'h1);
        tx_busy = 1'b1; step();
        tx_busy = 1'b0; step(); step();

        // test 4: busy never rises, load retried with same byte
        sb_on = 1'b0;
        wr_en = 1'b1; wr_data = 8'h77; step();
        wr_data = 8'h88; step();
        wr_en = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            step();
            seen = load;
        end
        chk("t4_first_load", {load, tx_din, count}, {1'b1, 8'h77, 5'd1});
        for (int r = 0; r < 3; r++) begin
            gap = 0;
            seen = 1'b0;
            for (int n = 0; n < 60 && !seen; n++) begin
                step();
                gap++;
                seen = load;
            end
            chk($sformatf("t4_retry%0d_gap", r), gap, BT + 2);
            chk($sformatf("t4_retry%0d_data", r), {load, tx_din, count}, {1'b1, 8'h77, 5'd1});
        end
        tx_busy = 1'b1; step();
        tx_busy = 1'b0; step();
        sb_on = 1'b1;
        sbq.push_back(8'h88);
        drain("t4");

        // test 5: async reset in WAIT_DONE with 5 bytes queued
        tx_busy = 1'b1; wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'hC0 + 8'(i); sbq.push_back(wr_data); step();
        end
        wr_en = 1'b0; tx_busy = 1'b0; step();
        tx_busy = 1'b1; step();
        chk("t5_load", {31'h0, load}, 32'h1);
        step();
        chk("t5_waitdone", {load, count}, {1'b0, 5'd5});
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_clear", {load, count, empty, full, tx_din}, {1'b0, 5'd0, 1'b1, 1'b0, 8'h00});
        rst_n = 1'b1;
        sbq.delete();
        tx_busy = 1'b0;
        n0 = nload;
        for (int n = 0; n < 40; n++) step();
        chk("t5_no_load_after_reset", nload - n0, 0);
        wr_en = 1'b1; wr_data = 8'h42; sbq.push_back(8'h42); step();
        wr_en = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            step();
            seen = load;
        end
        chk("t5_new_write_loads", {31'h0, seen}, 32'h1);
        // load is high here; it must drop with rst_n alone
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_load_drop", {load, tx_din}, {1'b0, 8'h00});
        rst_n = 1'b1;
        sbq.delete();
        step();

`ifdef XMIT_FIFO_OVF_EN
        // test 6: sticky overflow
        chk("t6_ovf_clear", {31'h0, ovf}, 32'h0);
        tx_busy = 1'b1; wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'h10 + 8'(i); sbq.push_back(wr_data); step();
        end
        chk("t6_full_no_ovf", {full, ovf}, {1'b1, 1'b0});
        wr_data = 8'hF0; step();
        wr_en = 1'b0;
        chk("t6_ovf_set", {full, ovf, count}, {1'b1, 1'b1, 5'd16});
        drain("t6");
        chk("t6_ovf_sticky", {31'h0, ovf}, 32'h1);
        do_reset();
        chk("t6_ovf_reset", {31'h0, ovf}, 32'h0);
`else
        do_reset();
`endif
        chk("end_state", {load, count, empty}, {1'b0, 5'd0, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
